lut_neuron_sweeper: RTL and testbench

- Drives the input side of one LUT neuron (IN_BITS-bit input code, OUT_BITS-bit output) through every input code, from 0 to 2^IN_BITS-1.
- Captures the neuron's responses, packs them into WORD_W-bit words and streams them out over a valid/ready interface.
- Used for on-chip readback and self-check of synthesized neuron tables against the trained model, and also reports a count of non-zero entries.

---
 rtl/lut_neuron_sweeper.sv | 158 +++++++++++++++
 tb/tb_lut_neuron_sweeper.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_sweeper.sv
// Sweeps one LUT neuron through every input code, packs the responses into
// WORD_W-bit words on a valid/ready stream and counts non-zero entries.
module lut_neuron_sweeper #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 32,
  parameter int LAT      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic [IN_BITS-1:0]  lut_in,
  input  logic [OUT_BITS-1:0] lut_out,
  output logic [WORD_W-1:0]   dout_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                done,
  output logic [IN_BITS:0]    ones_count
);

  localparam int E  = WORD_W / OUT_BITS;
  localparam int NW = (1 << IN_BITS) / E;
  localparam int SW = (E > 1) ? $clog2(E) : 1;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [WW-1:0]      word_q, word_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic [IN_BITS-1:0] lut_in_q, lut_in_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [IN_BITS:0]   ones_q, ones_d;

  logic          issue;
  logic          cap_vld;
  logic [SW-1:0] cap_slot;

  assign issue = (state_q == S_ISSUE);

  // Slot indices travel alongside the neuron pipeline so each late sample
  // lands in the word slot of the code that produced it.
  generate
    if (LAT == 0) begin : g_comb
      assign cap_vld  = issue;
      assign cap_slot = slot_q;
    end else begin : g_pipe
      logic [LAT-1:0]         vld_pipe;
      logic [LAT-1:0][SW-1:0] slot_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe  <= '0;
          slot_pipe <= '0;
        end else begin
          vld_pipe[0]  <= issue;
          slot_pipe[0] <= slot_q;
          for (int j = 1; j < LAT; j++) begin
            vld_pipe[j]  <= vld_pipe[j-1];
            slot_pipe[j] <= slot_pipe[j-1];
          end
        end
      end
      assign cap_vld  = vld_pipe[LAT-1];
      assign cap_slot = slot_pipe[LAT-1];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    word_d   = word_q;
    flush_d  = flush_q;
    lut_in_d = lut_in_q;
    data_d   = data_q;
    ones_d   = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          slot_d   = '0;
          word_d   = '0;
          flush_d  = '0;
          lut_in_d = '0;
          ones_d   = '0;
        end
      end
      S_ISSUE: begin
        if (slot_q == SW'(E-1)) begin
          slot_d  = '0;
          flush_d = '0;
          state_d = (LAT > 0) ? S_FLUSH : S_OUT;
        end else begin
          slot_d   = slot_q + SW'(1);
          lut_in_d = lut_in_q + IN_BITS'(1);
        end
      end
      S_FLUSH: begin
        if (flush_q == FW'(LAT-1)) state_d = S_OUT;
        else                       flush_d = flush_q + FW'(1);
      end
      S_OUT: begin
        if (dout_ready) begin
          if (word_q == WW'(NW-1)) begin
            state_d = S_DONE;
          end else begin
            word_d   = word_q + WW'(1);
            lut_in_d = lut_in_q + IN_BITS'(1);
            state_d  = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Captures never coincide with IDLE, so they cannot race the clear above.
    if (cap_vld) begin
      data_d[int'(cap_slot)*OUT_BITS +: OUT_BITS] = lut_out;
      if (lut_out != '0) ones_d = ones_q + (IN_BITS+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      word_q   <= '0;
      flush_q  <= '0;
      lut_in_q <= '0;
      data_q   <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      word_q   <= word_d;
      flush_q  <= flush_d;
      lut_in_q <= lut_in_d;
      data_q   <= data_d;
      ones_q   <= ones_d;
    end
  end

  assign busy       = (state_q == S_ISSUE) || (state_q == S_FLUSH) || (state_q == S_OUT);
  assign dout_valid = (state_q == S_OUT);
  assign dout_last  = dout_valid && (word_q == WW'(NW-1));
  assign done       = (state_q == S_DONE);
  assign lut_in     = lut_in_q;
  assign dout_data  = data_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_lut_neuron_sweeper.sv
// Directed bench: a combinational neuron stub (LAT=0) and a twice-registered
// stub (LAT=2), both sharing clock, reset, start and dout_ready.
module tb_lut_neuron_sweeper;

  logic clk = 1'b0;
  logic rst, start, dout_ready, mode;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  lut_in0, lut_in2;
  logic        lut_out0, lut_out2;
  logic [31:0] data0, data2;
  logic        valid0, valid2, last0, last2, done0, done2, busy0, busy2;
  logic [8:0]  ones0, ones2;
  logic        st1, st2;

  always #5 clk = ~clk;

  assign lut_out0 = mode ? (lut_in0 == 8'hFF) : lut_in0[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st1 <= 1'b0;
      st2 <= 1'b0;
    end else begin
      st1 <= mode ? (lut_in2 == 8'hFF) : lut_in2[0];
      st2 <= st1;
    end
  end
  assign lut_out2 = st2;

  lut_neuron_sweeper #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0),
    .lut_in(lut_in0), .lut_out(lut_out0),
    .dout_data(data0), .dout_valid(valid0), .dout_ready(dout_ready),
    .dout_last(last0), .done(done0), .ones_count(ones0));

  lut_neuron_sweeper #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2),
    .lut_in(lut_in2), .lut_out(lut_out2),
    .dout_data(data2), .dout_valid(valid2), .dout_ready(dout_ready),
    .dout_last(last2), .done(done2), .ones_count(ones2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sweep on the selected DUT: start pulse, optional 10-cycle stall
  // on stall_word, optional stray start once restart_word is being issued.
  task automatic run_sweep(input int sel, input logic [31:0] exp_w, input logic [31:0] exp_last,
                           input int exp_ones, input int exp_lat, input int stall_word,
                           input int restart_word);
    int idx = 0, n = 0, first = -1, dones = 0, stall = 0;
    bit restarted = 0;
    logic v, l, d, b;
    logic [31:0] dat;
    logic [7:0]  li;
    logic [8:0]  on;
    start = 1'b1;
    dout_ready = 1'b1;
    while (dones == 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (restart_word >= 0 && idx == restart_word && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      v   = (sel == 2) ? valid2 : valid0;
      l   = (sel == 2) ? last2  : last0;
      d   = (sel == 2) ? done2  : done0;
      b   = (sel == 2) ? busy2  : busy0;
      dat = (sel == 2) ? data2  : data0;
      li  = (sel == 2) ? lut_in2 : lut_in0;
      on  = (sel == 2) ? ones2  : ones0;
      if (d) begin
        dones++;
        check("busy_at_done", b, 0);
        check("ones_count", on, exp_ones);
      end
      if (v) begin
        if (first < 0) begin
          first = n;
          check("first_valid_latency", n, exp_lat);
        end
        if (idx == stall_word && stall < 10) begin
          dout_ready = 1'b0;
          check("stall_data", dat, exp_w);
          check("stall_lut_in", li, stall_word*32 + 31);
          stall++;
        end else begin
          dout_ready = 1'b1;
          check($sformatf("word%0d_data", idx), dat, (idx == 7) ? exp_last : exp_w);
          check($sformatf("word%0d_last", idx), l, (idx == 7));
          idx++;
        end
      end else begin
        dout_ready = 1'b1;
      end
    end
    check("word_count", idx, 8);
    check("done_count", dones, 1);
    @(posedge clk); #1;
    check("done_one_cycle", (sel == 2) ? done2 : done0, 0);
    start = 1'b0;
    dout_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dout_ready = 1'b1; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  busy0,  0);
    check("rst_valid", valid0, 0);
    check("rst_last",  last0,  0);
    check("rst_done",  done0,  0);
    check("rst_lut_in", lut_in0, 0);
    check("rst_data",  data0,  0);
    check("rst_ones",  ones0,  0);
    check("rst_busy2", busy2,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // alternating stub, combinational neuron
    run_sweep(0, 32'hAAAAAAAA, 32'hAAAAAAAA, 128, 33, -1, -1);

    // only code 255 responds
    mode = 1'b1;
    run_sweep(0, 32'h00000000, 32'h80000000, 1, 33, -1, -1);
    mode = 1'b0;

    // two-cycle neuron: same words, 35-cycle start-to-valid
    run_sweep(2, 32'hAAAAAAAA, 32'hAAAAAAAA, 128, 35, -1, -1);

    // backpressure on word 3
    run_sweep(0, 32'hAAAAAAAA, 32'hAAAAAAAA, 128, 33, 3, -1);

    // reset during ISSUE of word 4
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int k = 0;
      while (lut_in0 != 8'd133 && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
      check("reach_word4", lut_in0, 8'd133);
    end
    check("busy_before_rst", busy0, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  busy0,  0);
    check("arst_valid", valid0, 0);
    check("arst_done",  done0,  0);
    check("arst_ones",  ones0,  0);
    check("arst_busy2", busy2,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep(0, 32'hAAAAAAAA, 32'hAAAAAAAA, 128, 33, -1, -1);

    // stray start while word 2 is in progress
    run_sweep(0, 32'hAAAAAAAA, 32'hAAAAAAAA, 128, 33, -1, 2);
    check("idle_after_restart", busy0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
